// File: rtl/route_sequencer.sv
// Route sequencer: steps through a 16-entry action table on each node event,
// handshakes each action to the motion executor and stops after LAPS END markers.
module route_sequencer #(
    parameter int unsigned HOLDOFF = 250,
    parameter int unsigned LAPS    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic [3:0] cfg_wdata,
    input  logic       start,
    input  logic       node_event,
    output logic [2:0] act_code,
    output logic       act_valid,
    input  logic       act_ready,
    output logic       start_detecting,
    output logic [3:0] node_idx,
    output logic [3:0] lap_cnt,
    output logic       running,
    output logic       finished,
    output logic       overrun
);

    localparam int unsigned CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [3:0] TBL_INIT [16] = '{
        4'b0110, 4'b0001, 4'b0110, 4'b0110, 4'b1001, 4'b0110, 4'b1001, 4'b1110,
        4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111
    };

    localparam logic [2:0] CODE_END = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_NODE,
        S_ISSUE,
        S_HOLDOFF,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      tbl_q [16];
    logic [3:0]      tbl_d [16];
    logic [2:0]      code_q, code_d;
    logic            sd_q, sd_d;
    logic [3:0]      idx_q, idx_d;
    logic [3:0]      lap_q, lap_d;
    logic            ovr_q, ovr_d;
    logic            final_q, final_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      entry;
    logic [4:0]      lap_inc;

    assign entry   = tbl_q[idx_q];
    assign lap_inc = {1'b0, lap_q} + 5'd1;

    always_comb begin
        state_d = state_q;
        tbl_d   = tbl_q;
        code_d  = code_q;
        sd_d    = sd_q;
        idx_d   = idx_q;
        lap_d   = lap_q;
        ovr_d   = ovr_q;
        final_d = final_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_we) tbl_d[cfg_addr] = cfg_wdata;
                if (start) begin
                    state_d = S_WAIT_NODE;
                    idx_d   = '0;
                    lap_d   = '0;
                    ovr_d   = 1'b0;
                    final_d = 1'b0;
                end
            end
            S_WAIT_NODE: begin
                if (node_event) begin
                    state_d = S_ISSUE;
                    if (entry[2:0] != CODE_END) begin
                        code_d = entry[2:0];
                        sd_d   = entry[3];
                        idx_d  = idx_q + 4'd1;
                    end else if (lap_inc == 5'(LAPS)) begin
                        lap_d   = lap_inc[3:0];
                        code_d  = CODE_END;
                        sd_d    = 1'b0;
                        final_d = 1'b1;
                    end else begin
                        // Lap boundary: restart at entry 0 without spending a node event.
                        lap_d  = lap_inc[3:0];
                        code_d = tbl_q[0][2:0];
                        sd_d   = tbl_q[0][3];
                        idx_d  = 4'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (node_event) ovr_d = 1'b1;
                if (act_ready) begin
                    if (final_q) begin
                        state_d = S_DONE;
                        code_d  = CODE_END;
                    end else if (HOLDOFF == 0) begin
                        state_d = S_WAIT_NODE;
                    end else begin
                        state_d = S_HOLDOFF;
                        cnt_d   = CW'(HOLDOFF);
                    end
                end
            end
            S_HOLDOFF: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_WAIT_NODE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tbl_q   <= TBL_INIT;
            code_q  <= '0;
            sd_q    <= 1'b0;
            idx_q   <= '0;
            lap_q   <= '0;
            ovr_q   <= 1'b0;
            final_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tbl_q   <= tbl_d;
            code_q  <= code_d;
            sd_q    <= sd_d;
            idx_q   <= idx_d;
            lap_q   <= lap_d;
            ovr_q   <= ovr_d;
            final_q <= final_d;
            cnt_q   <= cnt_d;
        end
    end

    assign act_code        = code_q;
    assign act_valid       = (state_q == S_ISSUE);
    assign start_detecting = sd_q;
    assign node_idx        = idx_q;
    assign lap_cnt         = lap_q;
    assign running         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign finished        = (state_q == S_DONE);
    assign overrun         = ovr_q;

endmodule

// File: tb/tb_route_sequencer.sv
// Directed bench for route_sequencer with HOLDOFF=4, LAPS=2.
module tb_route_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [3:0] cfg_wdata = '0;
    logic       start = 1'b0;
    logic       node_event = 1'b0;
    logic [2:0] act_code;
    logic       act_valid;
    logic       act_ready = 1'b0;
    logic       start_detecting;
    logic [3:0] node_idx;
    logic [3:0] lap_cnt;
    logic       running;
    logic       finished;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] exp_run_code [17] = '{
        3'b110, 3'b001, 3'b110, 3'b110, 3'b001, 3'b110, 3'b001, 3'b110,
        3'b110, 3'b001, 3'b110, 3'b110, 3'b001, 3'b110, 3'b001, 3'b110, 3'b111
    };
    logic exp_run_sd [17] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0
    };
    logic [2:0] exp_wrap_code [16] = '{
        3'b110, 3'b001, 3'b110, 3'b110, 3'b001, 3'b110, 3'b001, 3'b110,
        3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011
    };

    route_sequencer #(.HOLDOFF(4), .LAPS(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .start           (start),
        .node_event      (node_event),
        .act_code        (act_code),
        .act_valid       (act_valid),
        .act_ready       (act_ready),
        .start_detecting (start_detecting),
        .node_idx        (node_idx),
        .lap_cnt         (lap_cnt),
        .running         (running),
        .finished        (finished),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_event();
        node_event = 1'b1;
        tick();
        node_event = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [3:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code"}, int'(act_code), 0);
        check({tag, "_valid"}, int'(act_valid), 0);
        check({tag, "_sd"}, int'(start_detecting), 0);
        check({tag, "_idx"}, int'(node_idx), 0);
        check({tag, "_lap"}, int'(lap_cnt), 0);
        check({tag, "_running"}, int'(running), 0);
        check({tag, "_finished"}, int'(finished), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        check_reset_outputs("rst");

        // Full two-lap run with the default table.
        act_ready = 1'b1;
        pulse_start();
        check("run_running", int'(running), 1);
        for (int i = 0; i < 17; i++) begin
            pulse_event();
            check($sformatf("run_code%0d", i), int'(act_code), int'(exp_run_code[i]));
            check($sformatf("run_sd%0d", i), int'(start_detecting), int'(exp_run_sd[i]));
            check($sformatf("run_valid%0d", i), int'(act_valid), 1);
            if (i == 8) begin
                check("run_lap1", int'(lap_cnt), 1);
                check("run_idx_after_lap", int'(node_idx), 1);
            end
            tick(9);
        end
        check("run_finished", int'(finished), 1);
        check("run_lap2", int'(lap_cnt), 2);
        check("run_done_code", int'(act_code), 7);
        check("run_done_valid", int'(act_valid), 0);
        check("run_done_running", int'(running), 0);

        // Stalled handshake, overrun, and holdoff masking.
        act_ready = 1'b0;
        pulse_start();
        check("rs_finished", int'(finished), 0);
        check("rs_lap", int'(lap_cnt), 0);
        pulse_event();
        for (int i = 0; i < 5; i++) begin
            node_event = (i == 1);
            tick();
            node_event = 1'b0;
            check($sformatf("hold_valid%0d", i), int'(act_valid), 1);
            check($sformatf("hold_code%0d", i), int'(act_code), 6);
        end
        check("ovr_set", int'(overrun), 1);
        check("ovr_idx", int'(node_idx), 1);
        act_ready = 1'b1;
        tick();
        check("accept_valid", int'(act_valid), 0);
        check("accept_running", int'(running), 1);
        pulse_event();
        check("holdoff_valid", int'(act_valid), 0);
        check("holdoff_idx", int'(node_idx), 1);
        tick(10);
        pulse_start();
        check("ovr_sticky", int'(overrun), 1);
        check("start_ignored_idx", int'(node_idx), 1);

        // Table write during a run is ignored; reset aborts a pending action.
        act_ready = 1'b0;
        cfg_write(4'd1, 4'b1011);
        pulse_event();
        check("runwr_code", int'(act_code), 1);
        check("runwr_sd", int'(start_detecting), 0);
        check("issue_valid", int'(act_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("midrst");

        // Program entries 8..15 and check wrap of node_idx at entry 15.
        for (int a = 8; a < 15; a++) cfg_write(4'(a), 4'b0000);
        cfg_write(4'd15, 4'b1011);
        act_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            pulse_event();
            check($sformatf("wrap_code%0d", i), int'(act_code), int'(exp_wrap_code[i]));
            if (i < 15) tick(9);
        end
        check("wrap_sd", int'(start_detecting), 1);
        check("wrap_idx", int'(node_idx), 0);
        check("wrap_lap", int'(lap_cnt), 0);
        tick(9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/route_sequencer.md
ROUTE_SEQUENCER -- requirements
Module: route_sequencer

Interface
REQ-001 Parameter HOLDOFF, default 250: clk cycles during which node_event is ignored after each accepted action.
REQ-002 Parameter LAPS, default 2: number of END markers to pass before the run stops.
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cfg_we  in  1  route-table write strobe.
REQ-006 cfg_addr  in  4  table entry index 0..15.
REQ-007 cfg_wdata  in  4  entry payload: bit3 = detect flag, bits[2:0] = action code.
REQ-008 start  in  1  single-cycle run request.
REQ-009 node_event  in  1  single-cycle pulse from the line follower on node detection (all three sensors on line).
REQ-010 act_code  out  3  action for the motion executor: 000 follow_line, 001 turn_R, 010 turn_Node_R, 011 turn_L, 110 go_st, 111 stop/END.
REQ-011 act_valid  out  1  act_code is valid.
REQ-012 act_ready  in  1  executor accepts act_code.
REQ-013 start_detecting  out  1  detect flag of the last issued entry.
REQ-014 node_idx  out  4  index of the next entry to consume.
REQ-015 lap_cnt  out  4  number of END markers passed.
REQ-016 running  out  1  high in any state other than IDLE and DONE.
REQ-017 finished  out  1  high in DONE.
REQ-018 overrun  out  1  sticky error flag.

Function
REQ-019 Table storage SHALL be 16 x 4 bits, written on cfg_we only in IDLE or DONE; cfg_we in any other state is ignored.
REQ-020 States SHALL be IDLE, WAIT_NODE, ISSUE, HOLDOFF and DONE.
REQ-021 IDLE/DONE + start: next cycle enter WAIT_NODE, node_idx=0, lap_cnt=0, overrun=0, finished=0.
REQ-022 start in any other state is ignored.
REQ-023 WAIT_NODE + node_event, entry=table[node_idx], code!=111: act_code=code, start_detecting=bit3, node_idx+1 (15 wraps to 0), enter ISSUE next cycle.
REQ-024 WAIT_NODE + node_event, code==111, lap_cnt+1==LAPS: lap_cnt+1, act_code=111, start_detecting=0, enter ISSUE and mark the run final.
REQ-025 WAIT_NODE + node_event, code==111, lap_cnt+1<LAPS: lap_cnt+1, issue table[0] (code and flag) in the same cycle, node_idx=1, enter ISSUE.
REQ-026 In ISSUE, act_valid=1 and act_code SHALL remain stable until act_ready is sampled high; the handshake completes in that cycle.
REQ-027 Handshake complete, non-final run: act_valid=0 next cycle, enter HOLDOFF with counter=HOLDOFF.
REQ-028 Handshake complete, final run: act_valid=0 next cycle, enter DONE.
REQ-029 HOLDOFF SHALL decrement its counter each cycle; node_event is ignored; at 0 enter WAIT_NODE. HOLDOFF=0 means direct entry to WAIT_NODE.
REQ-030 node_event in ISSUE SHALL set overrun=1 and change no other state.
REQ-031 DONE SHALL hold act_code=111 with act_valid=0.
REQ-032 act_ready while act_valid=0 SHALL be ignored.
REQ-033 start_detecting, act_code, node_idx and lap_cnt SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-034 reset has priority over all inputs.
REQ-035 On reset: state IDLE; act_valid=0, act_code=000, start_detecting=0, node_idx=0, lap_cnt=0, running=0, finished=0, overrun=0; any handshake in flight is aborted.
REQ-036 Table contents on reset: entries 0..7 = {0,110},{0,001},{0,110},{0,110},{1,001},{0,110},{1,001},{1,110}; entries 8..15 = {0,111}.

Verification
REQ-037 Default table, LAPS=2, HOLDOFF=4, act_ready tied 1, start, then 17 node_event pulses spaced 10 cycles -> codes 110,001,110,110,001,110,001,110 then table[0] 110 (lap_cnt=1) and entries 1..7, then 111; finished=1, lap_cnt=2.
REQ-038 act_ready low for 5 cycles after act_valid rises -> act_valid and act_code held 5 cycles; one-cycle acceptance; HOLDOFF entered the next cycle.
REQ-039 node_event 2 cycles after acceptance with HOLDOFF=4 -> ignored; node_idx unchanged; no act_valid.
REQ-040 node_event while act_valid=1 and act_ready=0 -> overrun=1; issued action unchanged; overrun cleared only by start or reset.
REQ-041 Write entry 15 = {1,011} with entries 0..14 non-END, then 16 node_events -> 16th issues 011 with start_detecting=1 and node_idx wraps to 0.
REQ-042 reset asserted in ISSUE with act_valid=1 -> next cycle all outputs at reset values; cfg_we during a run leaves the table unchanged.
